// File: rtl/rf_pkg.sv
// Shared definitions for the register-file write-port arbiter slice.
package rf_pkg;

  localparam int DW_DEFAULT = 32;
  localparam int AW_DEFAULT = 5;
  localparam int NUM_REGS   = 32;
  localparam int REG_ZERO   = 0;

  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_LSU = 1'b1
  } req_id_t;

endpackage

// File: rtl/rf_wport_arb_if.sv
// Write-port bus between the two writeback requesters and the arbiter.
// Optional read-forwarding signals are present only when RF_BYPASS_EN is defined.
interface rf_wport_arb_if #(
  parameter int DW = 32,
  parameter int AW = 5
);

  logic          req0_valid;
  logic [AW-1:0] req0_a3;
  logic [DW-1:0] req0_wr;
  logic          req0_ready;
  logic          req1_valid;
  logic [AW-1:0] req1_a3;
  logic [DW-1:0] req1_wr;
  logic          req1_ready;
  logic          wrenable;
  logic [AW-1:0] a3;
  logic [DW-1:0] wr;
  logic          gnt_id;
`ifdef RF_BYPASS_EN
  logic [AW-1:0] a1;
  logic [AW-1:0] a2;
  logic [DW-1:0] rf_rd1;
  logic [DW-1:0] rf_rd2;
  logic [DW-1:0] rd1;
  logic [DW-1:0] rd2;
`endif

  modport master (
    output req0_valid, req0_a3, req0_wr,
    output req1_valid, req1_a3, req1_wr,
    input  req0_ready, req1_ready,
    input  wrenable, a3, wr, gnt_id
`ifdef RF_BYPASS_EN
    ,
    output a1, a2, rf_rd1, rf_rd2,
    input  rd1, rd2
`endif
  );

  modport slave (
    input  req0_valid, req0_a3, req0_wr,
    input  req1_valid, req1_a3, req1_wr,
    output req0_ready, req1_ready,
    output wrenable, a3, wr, gnt_id
`ifdef RF_BYPASS_EN
    ,
    input  a1, a2, rf_rd1, rf_rd2,
    output rd1, rd2
`endif
  );

endinterface

// File: rtl/rf_wport_arb_rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, pointer advances on every grant.
module rr_arb2
  import rf_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output req_id_t    gnt_id
);

  req_id_t prio;

  // Grants are suppressed during reset so nothing is accepted while the write port is held idle.
  always_comb begin
    gnt = 2'b00;
    if (!rst) begin
      if (req[0] && req[1]) begin
        gnt = (prio == REQ_LSU) ? 2'b10 : 2'b01;
      end else begin
        gnt = req;
      end
    end
  end

  assign gnt_id = gnt[1] ? REQ_LSU : REQ_ALU;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio <= REQ_ALU;
    end else if (gnt[0]) begin
      prio <= REQ_LSU;
    end else if (gnt[1]) begin
      prio <= REQ_ALU;
    end
  end

endmodule

// File: rtl/rf_wport_arb.sv
// Register-file write-port arbiter: round-robin between ALU and load/mul writeback, 1-cycle registered write.
// Define RF_BYPASS_EN to add combinational forwarding of the presented write onto two read ports.
module rf_wport_arb
  import rf_pkg::*;
#(
  parameter int DW = DW_DEFAULT,
  parameter int AW = AW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  rf_wport_arb_if.slave bus
);

  logic [1:0]    req;
  logic [1:0]    gnt;
  req_id_t       sel_id;
  logic [AW-1:0] sel_a3;
  logic [DW-1:0] sel_wr;

  assign req = {bus.req1_valid, bus.req0_valid};

  rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .gnt    (gnt),
    .gnt_id (sel_id)
  );

  assign bus.req0_ready = gnt[0];
  assign bus.req1_ready = gnt[1];
  assign sel_a3 = gnt[1] ? bus.req1_a3 : bus.req0_a3;
  assign sel_wr = gnt[1] ? bus.req1_wr : bus.req0_wr;

  // Writes to r0 are acknowledged but never reach the register file.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.wrenable <= 1'b0;
      bus.a3       <= '0;
      bus.wr       <= '0;
      bus.gnt_id   <= 1'b0;
    end else if (|gnt) begin
      bus.wrenable <= (sel_a3 != AW'(REG_ZERO));
      bus.a3       <= sel_a3;
      bus.wr       <= sel_wr;
      bus.gnt_id   <= sel_id;
    end else begin
      bus.wrenable <= 1'b0;
    end
  end

`ifdef RF_BYPASS_EN
  assign bus.rd1 = (bus.wrenable && (bus.a3 == bus.a1) && (bus.a1 != AW'(REG_ZERO))) ? bus.wr : bus.rf_rd1;
  assign bus.rd2 = (bus.wrenable && (bus.a3 == bus.a2) && (bus.a2 != AW'(REG_ZERO))) ? bus.wr : bus.rf_rd2;
`endif

endmodule

// File: tb/tb_rf_wport_arb.sv
// Directed self-checking bench for rf_wport_arb; bypass checks are compiled only with RF_BYPASS_EN.
module tb_rf_wport_arb;

  localparam int DW = 32;
  localparam int AW = 5;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [DW-1:0] rfModel [32];

  rf_wport_arb_if #(.DW(DW), .AW(AW)) bus ();

  rf_wport_arb #(.DW(DW), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register-file model fed only by the write port, used to see what persists.
  always @(posedge clk) begin
    if (bus.wrenable) rfModel[bus.a3] <= bus.wr;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                               input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    bus.req0_valid = v0;
    bus.req0_a3    = a0;
    bus.req0_wr    = d0;
    bus.req1_valid = v1;
    bus.req1_a3    = a1;
    bus.req1_wr    = d1;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    applyStimulus(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 32; i++) rfModel[i] = '0;
`ifdef RF_BYPASS_EN
    bus.a1 = '0;
    bus.a2 = '0;
    bus.rf_rd1 = '0;
    bus.rf_rd2 = '0;
`endif
    rst = 1'b1;
    applyStimulus(1, 5, 32'h1234, 1, 6, 32'h5678);
    step();
    checkOutput("rst_ready0", {63'd0, bus.req0_ready}, 64'd0);
    checkOutput("rst_ready1", {63'd0, bus.req1_ready}, 64'd0);
    checkOutput("rst_wrenable", {63'd0, bus.wrenable}, 64'd0);
    checkOutput("rst_a3", {59'd0, bus.a3}, 64'd0);
    checkOutput("rst_wr", {32'd0, bus.wr}, 64'd0);
    checkOutput("rst_gnt_id", {63'd0, bus.gnt_id}, 64'd0);
    doReset();

    $display("[TB] single request");
    applyStimulus(1, 5, 32'hDEADBEEF, 0, 0, 0);
    checkOutput("single_ready0", {63'd0, bus.req0_ready}, 64'd1);
    checkOutput("single_ready1", {63'd0, bus.req1_ready}, 64'd0);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("single_wrenable", {63'd0, bus.wrenable}, 64'd1);
    checkOutput("single_a3", {59'd0, bus.a3}, 64'd5);
    checkOutput("single_wr", {32'd0, bus.wr}, 64'hDEADBEEF);
    checkOutput("single_gnt_id", {63'd0, bus.gnt_id}, 64'd0);
    step();
    checkOutput("single_idle_wrenable", {63'd0, bus.wrenable}, 64'd0);
    checkOutput("single_hold_a3", {59'd0, bus.a3}, 64'd5);
    checkOutput("single_hold_wr", {32'd0, bus.wr}, 64'hDEADBEEF);

    $display("[TB] sustained dual requests");
    doReset();
    applyStimulus(1, 10, 32'hA0, 1, 11, 32'hB1);
    for (int i = 0; i < 4; i++) begin
      checkOutput("dual_ready0", {63'd0, bus.req0_ready}, (i % 2 == 0) ? 64'd1 : 64'd0);
      checkOutput("dual_ready1", {63'd0, bus.req1_ready}, (i % 2 == 1) ? 64'd1 : 64'd0);
      step();
      checkOutput("dual_wrenable", {63'd0, bus.wrenable}, 64'd1);
      checkOutput("dual_gnt_id", {63'd0, bus.gnt_id}, 64'(i % 2));
      checkOutput("dual_a3", {59'd0, bus.a3}, (i % 2 == 0) ? 64'd10 : 64'd11);
      checkOutput("dual_wr", {32'd0, bus.wr}, (i % 2 == 0) ? 64'hA0 : 64'hB1);
    end
    applyStimulus(0, 0, 0, 0, 0, 0);
    step();
    checkOutput("dual_end_wrenable", {63'd0, bus.wrenable}, 64'd0);

    $display("[TB] address collision");
    doReset();
    applyStimulus(1, 7, 32'h11, 1, 7, 32'h22);
    checkOutput("coll_ready0", {63'd0, bus.req0_ready}, 64'd1);
    checkOutput("coll_ready1", {63'd0, bus.req1_ready}, 64'd0);
    step();
    applyStimulus(0, 0, 0, 1, 7, 32'h22);
    checkOutput("coll_first_wr", {32'd0, bus.wr}, 64'h11);
    checkOutput("coll_first_we", {63'd0, bus.wrenable}, 64'd1);
    checkOutput("coll_pending_ready1", {63'd0, bus.req1_ready}, 64'd1);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("coll_second_wr", {32'd0, bus.wr}, 64'h22);
    checkOutput("coll_second_gnt_id", {63'd0, bus.gnt_id}, 64'd1);
    checkOutput("coll_second_we", {63'd0, bus.wrenable}, 64'd1);
    step();
    checkOutput("coll_reg7", {32'd0, rfModel[7]}, 64'h22);
    checkOutput("coll_end_we", {63'd0, bus.wrenable}, 64'd0);

    $display("[TB] r0 write advances pointer");
    doReset();
    applyStimulus(1, 2, 32'h2, 0, 0, 0);
    step();
    applyStimulus(0, 0, 0, 1, 0, 32'hFFFF);
    checkOutput("r0_ready1", {63'd0, bus.req1_ready}, 64'd1);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("r0_wrenable", {63'd0, bus.wrenable}, 64'd0);
    applyStimulus(1, 4, 32'h44, 1, 6, 32'h66);
    checkOutput("r0_next_ready0", {63'd0, bus.req0_ready}, 64'd1);
    checkOutput("r0_next_ready1", {63'd0, bus.req1_ready}, 64'd0);
    step();
    applyStimulus(0, 0, 0, 1, 6, 32'h66);
    checkOutput("r0_next_gnt_id", {63'd0, bus.gnt_id}, 64'd0);
    checkOutput("r0_next_a3", {59'd0, bus.a3}, 64'd4);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("r0_then_gnt_id", {63'd0, bus.gnt_id}, 64'd1);
    checkOutput("r0_then_wr", {32'd0, bus.wr}, 64'h66);

    $display("[TB] reset mid-operation");
    doReset();
    applyStimulus(1, 9, 32'h99, 0, 0, 0);
    step();
    checkOutput("midrst_pre_we", {63'd0, bus.wrenable}, 64'd1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midrst_async_we", {63'd0, bus.wrenable}, 64'd0);
    checkOutput("midrst_ready0", {63'd0, bus.req0_ready}, 64'd0);
    checkOutput("midrst_a3", {59'd0, bus.a3}, 64'd0);
    step();
    step();
    checkOutput("midrst_held_we", {63'd0, bus.wrenable}, 64'd0);
    rst = 1'b0;
    #1;
    checkOutput("midrst_release_we", {63'd0, bus.wrenable}, 64'd0);
    checkOutput("midrst_release_ready0", {63'd0, bus.req0_ready}, 64'd1);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("midrst_regrant_we", {63'd0, bus.wrenable}, 64'd1);
    checkOutput("midrst_regrant_a3", {59'd0, bus.a3}, 64'd9);

`ifdef RF_BYPASS_EN
    $display("[TB] bypass");
    applyStimulus(1, 3, 32'hABCD, 0, 0, 0);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0);
    bus.a1 = 5'd3;
    bus.rf_rd1 = 32'h0;
    bus.a2 = 5'd3;
    bus.rf_rd2 = 32'h7;
    #1;
    checkOutput("byp_rd1_fwd", {32'd0, bus.rd1}, 64'hABCD);
    checkOutput("byp_rd2_fwd", {32'd0, bus.rd2}, 64'hABCD);
    bus.a1 = 5'd0;
    bus.rf_rd1 = 32'h5555;
    bus.a2 = 5'd4;
    #1;
    checkOutput("byp_rd1_r0", {32'd0, bus.rd1}, 64'h5555);
    checkOutput("byp_rd2_miss", {32'd0, bus.rd2}, 64'h7);
    step();
    bus.a1 = 5'd3;
    bus.rf_rd1 = 32'h1;
    #1;
    checkOutput("byp_rd1_idle", {32'd0, bus.rd1}, 64'h1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rf_wport_arb.md
RF_WPORT_ARB -- requirements
Module: rf_wport_arb

Interface
REQ-001 The block SHALL have parameter DW, default 32, meaning write-data width.
REQ-002 The block SHALL have parameter AW, default 5, meaning register address width.
REQ-003 The block SHALL have port clk, input, 1, meaning the single clock; all state SHALL update on posedge clk.
REQ-004 The block SHALL have port rst, input, 1, meaning reset, asynchronous and active-high.
REQ-005 The block SHALL have ports req0_valid/req1_valid, input, 1 each, meaning writeback request from the ALU stage (0) and the load/mul stage (1).
REQ-006 The block SHALL have ports req0_a3/req1_a3, input, AW each, meaning destination register.
REQ-007 The block SHALL have ports req0_wr/req1_wr, input, DW each, meaning write data.
REQ-008 The block SHALL have ports req0_ready/req1_ready, output, 1 each, meaning request accepted this cycle.
REQ-009 The block SHALL have port wrenable, output, 1, meaning register-file write enable.
REQ-010 The block SHALL have port a3, output, AW, meaning register-file write address.
REQ-011 The block SHALL have port wr, output, DW, meaning register-file write data.
REQ-012 The block SHALL have port gnt_id, output, 1, meaning the requester whose write is currently presented.

Function
REQ-013 The block SHALL accept a request when reqN_valid and reqN_ready are both high at a posedge.
REQ-014 reqN_ready SHALL be combinational, with at most one ready high per cycle, and readyN SHALL be high only when reqN_valid is high.
REQ-015 A single valid request SHALL be granted immediately.
REQ-016 With both requests valid, the grant SHALL be round-robin: the requester not granted last wins.
REQ-017 The round-robin pointer SHALL update only on an accepted grant.
REQ-018 The latency SHALL be exactly 1 cycle: a grant accepted at edge N SHALL drive wrenable/a3/wr/gnt_id as registered values during cycle N+1, so the register file commits at edge N+1.
REQ-019 A cycle with no accepted grant SHALL register wrenable=0; a3, wr and gnt_id SHALL hold their last values.
REQ-020 An accepted request with a3==0 SHALL be acknowledged (ready high) but SHALL register wrenable=0, and the round-robin pointer SHALL still advance.
REQ-021 On an address collision (both valid, same a3), the loser SHALL stay pending and be granted next cycle, so the later-granted data persists in the register file.
REQ-022 A requester SHALL hold valid, a3 and wr stable until ready; the block SHALL NOT buffer ungranted requests.
REQ-023 Sustained dual requests SHALL alternate 0,1,0,1 at full throughput (one write per cycle), with no starvation.

Reset
REQ-024 While rst is high, wrenable, a3, wr and gnt_id SHALL be 0, and the round-robin pointer SHALL give priority to requester 0.
REQ-025 While rst is high, req0_ready and req1_ready SHALL be 0.
REQ-026 Asserting rst mid-operation SHALL drop any presented write within the same cycle (wrenable=0 asynchronously); no write SHALL be issued after reset release without a new accept.

Configuration
REQ-027 The macro RF_BYPASS_EN, when defined, SHALL add:
- inputs a1, a2 (AW) and rf_rd1, rf_rd2 (DW);
- outputs rd1, rd2 (DW), where rdX = wr when wrenable and a3==aX and aX!=0, else rf_rdX (combinational forwarding of the presented write).
REQ-028 Without RF_BYPASS_EN, those ports and that logic SHALL be absent, and the rest of the behaviour SHALL be identical.

Structure
REQ-029 A shared package rf_pkg SHALL hold:
- the DW/AW defaults;
- the register count 32;
- the constant REG_ZERO = 0;
- a requester-id typedef.
REQ-030 The round-robin decision (2 requests, pointer, grant, pointer update) SHALL be a sub-module rr_arb2; the output registers and bypass SHALL live in rf_wport_arb.

Verification
REQ-031 Bench scenario, single request: req0 {a3=5, wr=0xDEADBEEF} alone at edge N -> req0_ready=1 in cycle N; wrenable=1, a3=5, wr=0xDEADBEEF, gnt_id=0 in cycle N+1; wrenable=0 in cycle N+2.
REQ-032 Bench scenario, sustained dual requests: both valid for 4 cycles after reset -> grant order 0,1,0,1; wrenable high on 4 consecutive cycles.
REQ-033 Bench scenario, collision: req0 {a3=7, wr=0x11} and req1 {a3=7, wr=0x22} together after reset -> writes 0x11 then 0x22; register 7 ends at 0x22.
REQ-034 Bench scenario, r0 write: req1 {a3=0, wr=0xFFFF} -> req1_ready=1 and wrenable stays 0; a following dual request grants req0 first.
REQ-035 Bench scenario, reset mid-operation: rst raised during a cycle with wrenable=1 -> wrenable=0 within that cycle; the held request is re-granted only after rst falls.
REQ-036 Bench scenario, bypass (RF_BYPASS_EN): presented write a3=3, wr=0xABCD with a1=3, rf_rd1=0x0 -> rd1=0xABCD; with a1=0 -> rd1=rf_rd1.
